serial_adder: RTL

//  Multi-cycle, digit-serial two's-complement adder for the ALU datapath.

---
 rtl/serial_adder.sv | 113 +++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial two's-complement adder: DIGIT bits per cycle, carry held in a flop; optional subtract via `SERIAL_ADDER_SUB_EN.
// Latency: done pulses NDIG cycles after the accepting edge; one op per NDIG+1 cycles.
// Backpressure: none queued; start is accepted only while busy=0 (IDLE or the DONE cycle).
module serial_adder #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             subMode,
`endif
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       statusOut
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry_q;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             sub_en;
    logic [WIDTH-1:0] b_in;
    logic [DIGIT:0]   digit_sum;
    logic [WIDTH-1:0] a_next;
    logic             last_digit;
    logic             accept;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_en = subMode;
`else
    assign sub_en = 1'b0;
`endif

    // Subtraction is A + ~B + 1: the +1 enters through the initial carry.
    assign b_in       = sub_en ? ~operand2 : operand2;
    assign accept     = start && (state != RUN);
    assign last_digit = (cnt == CW'(NDIG - 1));
    assign digit_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    // a_q doubles as the sum register: each step consumes its low digit and
    // shifts the new sum digit in at the top, so after NDIG steps it holds the sum.
    generate
        if (NDIG == 1) begin : g_single
            assign a_next = digit_sum[DIGIT-1:0];
        end else begin : g_multi
            assign a_next = {digit_sum[DIGIT-1:0], a_q[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            result    <= '0;
            statusOut <= 4'b0000;
        end else begin
            case (state)
                RUN: begin
                    a_q     <= a_next;
                    b_q     <= b_q >> DIGIT;
                    carry_q <= digit_sum[DIGIT];
                    cnt     <= cnt + CW'(1);
                    if (last_digit) begin
                        result    <= a_next;
                        statusOut <= {a_next[WIDTH-1],
                                      (a_next == '0),
                                      digit_sum[DIGIT],
                                      (a_msb == b_msb) && (a_next[WIDTH-1] != a_msb)};
                        state     <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        a_q     <= operand1;
                        b_q     <= b_in;
                        a_msb   <= operand1[WIDTH-1];
                        b_msb   <= b_in[WIDTH-1];
                        carry_q <= sub_en;
                        cnt     <= '0;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
